// File: rtl/fp_add_stream_driver.sv
// fp_add_stream_driver
//   Initiator side of a fixed-latency FP32 adder. Operand pairs arrive on a
//   valid/ready stream and go straight to an external STAGES-deep adder. A
//   valid-tag shift register marks which adder slots hold real work. Each
//   tagged result is captured into a result FIFO, which feeds a valid/ready
//   output stream. Issue is credit-limited (FIFO occupancy plus in-flight
//   tags never exceeds FIFO_DEPTH), so a captured result always has a slot.
//
// Handshake semantics (both streams): a transfer happens at a rising clk
// edge when valid and ready are both high at that edge. The producer keeps
// valid and its data stable until the transfer. ready never depends on
// valid.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           synchronous clear of in-flight tags and FIFO
//   in_valid/ready  operand stream handshake, in_a/in_b operands
//   op_a/op_b       operands to the adder (combinational passthrough)
//   res_in          adder result, valid STAGES edges after issue
//   out_valid/ready result stream handshake, out_data = FIFO head
//   busy            any tag in flight or FIFO non-empty
module fp_add_stream_driver #(
    parameter int STAGES     = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    input  logic [31:0] res_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fp_add_stream_driver: STAGES must be in 1..4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fp_add_stream_driver: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [STAGES-1:0] vld_q, vld_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [31:0]       out_data_q, out_data_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic [CW:0]       inflight;
    logic [CW:0]       credit_used;
    logic              fire;
    logic              push;
    logic              pop;

    assign op_a = in_a;
    assign op_b = in_b;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight = inflight + (CW+1)'(vld_q[i]);
        end
    end

    // No same-cycle pop bypass: a slot freed by a pop becomes credit one
    // edge later, which keeps in_ready a function of registers plus
    // reset/flush only.
    assign credit_used = {1'b0, count_q} + inflight;
    assign in_ready    = !reset && !flush && (credit_used < (CW+1)'(FIFO_DEPTH));

    assign fire      = in_valid && in_ready;
    assign push      = vld_q[STAGES-1] && !flush;
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign busy      = (vld_q != '0) || (count_q != '0);
    assign out_data  = out_data_q;

    always_comb begin
        vld_d      = '0;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        out_data_d = out_data_q;

        vld_d[0] = fire;
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i] = vld_q[i-1];
        end

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);

        // out_data is a register holding the head entry after this edge.
        // When the slot being written is the new head (FIFO empty after any
        // pop), the head comes from res_in rather than the stale array.
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            out_data_d = res_in;
        end else begin
            out_data_d = mem_q[rd_ptr_d];
        end

        if (flush) begin
            vld_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            out_data_d = out_data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries exist.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= res_in;
        end
    end

    // Credits guarantee a tagged result always finds a free slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && (count_q == CW'(FIFO_DEPTH))));
        end
    end

endmodule

// File: tb/tb_fp_add_stream_driver.sv
module tb_fp_add_stream_driver;
    localparam int STAGES     = 4;
    localparam int FIFO_DEPTH = 8;
    localparam logic [31:0] FP_ONE = 32'h3F800000;
    localparam logic [31:0] FP_TWO = 32'h40000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int fires = 0;
    int pops  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pipe_q [STAGES];

    always #5 clk = ~clk;

    fp_add_stream_driver #(
        .STAGES    (STAGES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .op_a     (op_a),
        .op_b     (op_b),
        .res_in   (res_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    // Integer-valued FP32 helpers: operands are small non-negative integers,
    // so every sum is exact and the reference adder needs no rounding.
    function automatic logic [31:0] int_to_fp32(input int n);
        int msb;
        logic [31:0] u;
        if (n <= 0) return 32'h0;
        msb = 0;
        for (int i = 0; i < 24; i++) if (n[i]) msb = i;
        u = 32'(n) << (23 - msb);
        return {1'b0, 8'(127 + msb), u[22:0]};
    endfunction

    function automatic int fp32_to_int(input logic [31:0] f);
        int e;
        logic [23:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        if (e < 0 || e > 23) return 0;
        m = {1'b1, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return int_to_fp32(fp32_to_int(a) + fp32_to_int(b));
    endfunction

    function automatic logic [31:0] rnd_op();
        return int_to_fp32(int'($urandom_range(0, 1000)));
    endfunction

    // Behavioural adder: samples op_a/op_b every edge, result appears
    // STAGES edges later.
    always @(posedge clk) begin
        pipe_q[0] <= fp_add(op_a, op_b);
        for (int i = 1; i < STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign res_in = pipe_q[STAGES-1];

    // Scoreboard: sampled at negedge, ahead of the edge where the transfer
    // happens. Issued pairs queue their expected sum; popped results must
    // match the queue head. Reset and flush discard everything outstanding.
    always @(negedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got %h with no result outstanding", out_data);
                end else if (out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL sb_data: got %h expected %h", out_data, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(fp_add(in_a, in_b));
                fires++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((out_valid || busy) && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = 32'h0; in_b = 32'h0;
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        step();
        reset = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_single();
        out_ready = 1'b0;
        in_a = FP_ONE; in_b = FP_TWO; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            n_cmp++;
            if (out_valid !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_wait: cycle %0d out_valid=%b busy=%b want 0/1", k, out_valid, busy);
            end
            step();
        end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== 32'h40400000) begin n_err++; $display("FAIL single_sum: got %h want 40400000", out_data); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int p0;
        logic exp_ov;
        p0 = pops;
        out_ready = 1'b1;
        for (int c = 0; c < 16 + STAGES + 2; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; in_a = int_to_fp32(c); in_b = FP_ONE;
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: item %0d got %b want 1", c, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
            step();
            exp_ov = (c >= STAGES) && (c < STAGES + 16);
            n_cmp++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL b2b_valid: cycle %0d got %b want %b", c, out_valid, exp_ov); end
        end
        n_cmp++; if (pops - p0 != 16) begin n_err++; $display("FAIL b2b_count: got %0d want 16", pops - p0); end
    endtask

    task automatic test_backpressure();
        int f0;
        int p0;
        f0 = fires;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < FIFO_DEPTH + STAGES + 4; c++) begin
            in_a = rnd_op(); in_b = rnd_op();
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (fires - f0 != FIFO_DEPTH) begin n_err++; $display("FAIL bp_fires: got %0d want %0d", fires - f0, FIFO_DEPTH); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_full_valid: got %b want 1", out_valid); end
        p0 = pops;
        out_ready = 1'b1;
        step();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_credit: got %b want 1", in_ready); end
        drain(4 * FIFO_DEPTH);
        n_cmp++; if (pops - p0 != FIFO_DEPTH || busy !== 1'b0) begin n_err++; $display("FAIL bp_drain: pops %0d busy %b want %0d/0", pops - p0, busy, FIFO_DEPTH); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            in_a = rnd_op(); in_b = rnd_op();
            step();
        end
        in_valid = 1'b0;
        repeat (STAGES) step();
        for (int it = 0; it < 3 * FIFO_DEPTH; it++) begin
            in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op();
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wrap_ready: iter %0d got %b want 1", it, in_ready); end
            step();
            in_valid = 1'b0;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL wrap_credit: iter %0d got %b want 0", it, in_ready); end
            repeat (STAGES - 1) step();
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL wrap_count: iter %0d in_ready=%b out_valid=%b want 1/1", it, in_ready, out_valid);
            end
        end
        drain(4 * FIFO_DEPTH);
        n_cmp++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL wrap_drain: busy %b left %0d want 0/0", busy, exp_q.size()); end
    endtask

    task automatic test_flush();
        int p0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin in_a = rnd_op(); in_b = rnd_op(); step(); end
        in_valid = 1'b0;
        repeat (STAGES) step();
        in_valid = 1'b1;
        repeat (2) begin in_a = rnd_op(); in_b = rnd_op(); step(); end
        in_valid = 1'b0;
        flush = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        repeat (STAGES + 2) step();
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_late: out_valid=%b busy=%b want 0/0", out_valid, busy);
        end
        p0 = pops;
        in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op();
        step();
        drain(4 * STAGES + 4);
        n_cmp++; if (pops - p0 != 1 || busy !== 1'b0) begin n_err++; $display("FAIL flush_after: pops %0d busy %b want 1/0", pops - p0, busy); end
    endtask

    task automatic test_reset_mid();
        int p0;
        for (int c = 0; c < 12; c++) begin
            in_valid  = 1'b1;
            in_a      = rnd_op(); in_b = rnd_op();
            out_ready = ($urandom_range(0, 3) == 0);
            step();
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset: out_valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready);
        end
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        p0 = pops;
        in_valid = 1'b1; in_a = rnd_op(); in_b = rnd_op();
        step();
        drain(4 * STAGES + 4);
        n_cmp++; if (pops - p0 != 1 || busy !== 1'b0) begin n_err++; $display("FAIL mid_after: pops %0d busy %b want 1/0", pops - p0, busy); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = rnd_op(); in_b = rnd_op();
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain(4 * (FIFO_DEPTH + STAGES));
        n_cmp++; if (busy !== 1'b0 || exp_q.size() != 0) begin n_err++; $display("FAIL rand_drain: busy %b left %0d want 0/0", busy, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
